// File: rtl/float_div_seq_pkg.sv
// Shared types and constants for the sequential float divider.
// FLOAT_DIV_ROUND_EN adds a guard iteration and round-to-nearest-even.
package float_pack;

    localparam int Nm = 23;
    localparam int Ne = 8;
    localparam int De = 2 ** (Ne - 1) - 1;
    localparam int EMAX = 2 ** Ne - 2;

`ifdef FLOAT_DIV_ROUND_EN
    localparam int DIV_ITERS = Nm + 3;
`else
    localparam int DIV_ITERS = Nm + 2;
`endif

    typedef struct packed {
        logic          s;
        logic [Ne-1:0] e;
        logic [Nm-1:0] m;
    } float_t;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } div_state_t;

endpackage

// File: rtl/float_div_seq_core.sv
// One restoring-division step: compare, conditionally subtract, shift.
module float_div_core #(
    parameter int NM = 23
) (
    input  logic [NM+1:0] rem,
    input  logic [NM:0]   divisor,
    output logic [NM+1:0] next_rem,
    output logic          q_bit
);

    logic [NM+1:0] diff;
    logic [NM+1:0] kept;

    always_comb begin
        diff     = rem - {1'b0, divisor};
        q_bit    = (rem >= {1'b0, divisor});
        kept     = q_bit ? diff : rem;
        // kept < divisor, so its MSB is always zero and the shift loses nothing.
        next_rem = kept << 1;
    end

endmodule

// File: rtl/float_div_seq.sv
// Multi-cycle restoring float divider with valid/ready on both sides.
// Optional rounding: define FLOAT_DIV_ROUND_EN (default is truncation).
module float_div_seq
    import float_pack::*;
#(
    parameter bit EARLY_OUT = 1'b1,
    parameter int NM        = Nm,
    parameter int NE        = Ne
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NE+NM:0]    a,
    input  logic [NE+NM:0]    b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NE+NM:0]    q,
    output logic              div_by_zero
);

`ifdef FLOAT_DIV_ROUND_EN
    localparam int ITERS = NM + 3;
`else
    localparam int ITERS = NM + 2;
`endif
    localparam int QW = ITERS;
    localparam int CW = $clog2(ITERS + 1);

    localparam logic [CW-1:0]        LAST_ITER = CW'(ITERS - 1);
    localparam logic [NE-1:0]        EMAX_E    = {{(NE - 1){1'b1}}, 1'b0};
    localparam logic signed [NE+1:0] EMAX_S    = {2'b00, EMAX_E};
    localparam logic signed [NE+1:0] DE_S      = {3'b000, {(NE - 1){1'b1}}};
    localparam logic signed [NE+1:0] ONE_S     = 1;
    localparam logic signed [NE+1:0] ZERO_S    = 0;

    div_state_t           state;
    logic [CW-1:0]        iter_cnt;
    logic [NM+1:0]        rem;
    logic [NM:0]          divisor;
    logic [QW-1:0]        quo;
    logic                 sign;
    logic                 a_zero;
    logic                 b_zero;
    logic signed [NE+1:0] exp_raw;

    logic [NM+1:0]        next_rem;
    logic                 q_bit;

    logic                 a_s, b_s;
    logic [NE-1:0]        a_e, b_e;
    logic [NM-1:0]        a_m, b_m;

    logic                 int_bit;
    logic signed [NE+1:0] exp_n;
    logic [NM-1:0]        man;
    logic [NE-1:0]        res_e;
    logic [NM-1:0]        res_m;
`ifdef FLOAT_DIV_ROUND_EN
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [NM:0]          man_sum;
`endif

    assign {a_s, a_e, a_m} = a;
    assign {b_s, b_e, b_m} = b;

    float_div_core #(.NM(NM)) u_core (
        .rem      (rem),
        .divisor  (divisor),
        .next_rem (next_rem),
        .q_bit    (q_bit)
    );

    // Normalisation, optional rounding and range clamping of the finished quotient.
    always_comb begin
        int_bit = quo[QW-1];
        exp_n   = int_bit ? exp_raw : exp_raw - ONE_S;
`ifdef FLOAT_DIV_ROUND_EN
        if (int_bit) begin
            man    = quo[NM+1:2];
            guard  = quo[1];
            sticky = quo[0] | (|rem);
        end else begin
            man    = quo[NM:1];
            guard  = quo[0];
            sticky = |rem;
        end
        round_up = guard & (sticky | man[0]);
        man_sum  = {1'b0, man} + (NM + 1)'(round_up);
        man      = man_sum[NM-1:0];
        exp_n    = exp_n + $signed({{(NE + 1){1'b0}}, man_sum[NM]});
`else
        man = int_bit ? quo[NM:1] : quo[NM-1:0];
`endif
        res_e = '0;
        res_m = '0;
        if (b_zero) begin
            res_e = EMAX_E;
            res_m = '1;
        end else if (a_zero) begin
            res_e = '0;
            res_m = '0;
        end else if (exp_n > EMAX_S) begin
            res_e = EMAX_E;
            res_m = '1;
        end else if (exp_n <= ZERO_S) begin
            res_e = '0;
            res_m = '0;
        end else begin
            res_e = exp_n[NE-1:0];
            res_m = man;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            q           <= '0;
            div_by_zero <= 1'b0;
            iter_cnt    <= '0;
            rem         <= '0;
            divisor     <= '0;
            quo         <= '0;
            sign        <= 1'b0;
            a_zero      <= 1'b0;
            b_zero      <= 1'b0;
            exp_raw     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign     <= a_s ^ b_s;
                        a_zero   <= (a_e == '0);
                        b_zero   <= (b_e == '0);
                        rem      <= {2'b01, a_m};
                        divisor  <= {1'b1, b_m};
                        quo      <= '0;
                        exp_raw  <= $signed({2'b00, a_e}) - $signed({2'b00, b_e}) + DE_S;
                        iter_cnt <= '0;
                        in_ready <= 1'b0;
                        // Special cases skip iteration; NORM resolves them from the flags.
                        if (EARLY_OUT && ((a_e == '0) || (b_e == '0)))
                            state <= NORM;
                        else
                            state <= DIV;
                    end
                end
                DIV: begin
                    rem <= next_rem;
                    quo <= {quo[QW-2:0], q_bit};
                    if (iter_cnt == LAST_ITER) begin
                        iter_cnt <= '0;
                        state    <= NORM;
                    end else begin
                        iter_cnt <= iter_cnt + 1'b1;
                    end
                end
                NORM: begin
                    q           <= {sign, res_e, res_m};
                    div_by_zero <= b_zero;
                    out_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_div_seq.sv
// Scoreboard bench for float_div_seq (NE=8, NM=23, EARLY_OUT=1).
module tb_float_div_seq;

    typedef struct {
        logic [31:0] q;
        logic        dbz;
        int          lat;
    } exp_t;

`ifdef FLOAT_DIV_ROUND_EN
    localparam int FULL_LAT   = 27;
    localparam logic [31:0] ONE_THIRD  = 32'h3EAAAAAB;
    localparam logic [31:0] FOUR_THIRD = 32'h3FAAAAAB;
`else
    localparam int FULL_LAT   = 26;
    localparam logic [31:0] ONE_THIRD  = 32'h3EAAAAAA;
    localparam logic [31:0] FOUR_THIRD = 32'h3FAAAAAA;
`endif
    localparam int EARLY_LAT = 1;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q;
    logic        div_by_zero;

    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    float_div_seq dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .q           (q),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Drive one operand pair, then check latency, result and hand-off.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] qv, input logic dz,
                          input int lat, input int stall);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_wait", {31'b0, in_ready}, 32'd1);
        a         = av;
        b         = bv;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        sb.push_back('{qv, dz, lat});
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check("latency", 32'(n), 32'(e.lat));
        check("q", q, e.q);
        check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
        if (stall > 0) begin
            a        = 32'h3F800000;
            b        = 32'h3F800000;
            in_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                check("stall_q", q, e.q);
                check("stall_valid", {31'b0, out_valid}, 32'd1);
                check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("consumed_valid", {31'b0, out_valid}, 32'd0);
        check("consumed_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        #23;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_q", q, 32'd0);
        check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, FULL_LAT, 0);
        run_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, FULL_LAT, 0);
        run_op(32'h3F800000, 32'h40400000, ONE_THIRD,    1'b0, FULL_LAT, 0);
        run_op(32'h40000000, 32'h3FC00000, FOUR_THIRD,   1'b0, FULL_LAT, 0);
        run_op(32'h40400000, 32'h40000000, 32'h3FC00000, 1'b0, FULL_LAT, 0);
        run_op(32'hBF800000, 32'hBF800000, 32'h3F800000, 1'b0, FULL_LAT, 0);
        run_op(32'h3F800000, 32'h40000000, 32'h3F000000, 1'b0, FULL_LAT, 0);
        run_op(32'h3F800000, 32'h00000000, 32'h7F7FFFFF, 1'b1, EARLY_LAT, 0);
        run_op(32'h3F800000, 32'h80000000, 32'hFF7FFFFF, 1'b1, EARLY_LAT, 0);
        run_op(32'h00000000, 32'h00000000, 32'h7F7FFFFF, 1'b1, EARLY_LAT, 0);
        run_op(32'h00000000, 32'h40000000, 32'h00000000, 1'b0, EARLY_LAT, 0);
        run_op(32'h80000000, 32'h40000000, 32'h80000000, 1'b0, EARLY_LAT, 0);
        run_op(32'h71800000, 32'h0D800000, 32'h7F7FFFFF, 1'b0, FULL_LAT, 0);
        run_op(32'h0D800000, 32'h71800000, 32'h00000000, 1'b0, FULL_LAT, 0);
        run_op(32'h7F7FFFFF, 32'h00800000, 32'h7F7FFFFF, 1'b0, FULL_LAT, 0);
        run_op(32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, FULL_LAT, 0);
        run_op(32'h00800000, 32'h40000000, 32'h00000000, 1'b0, FULL_LAT, 0);

        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, FULL_LAT, 5);

        // Abort an operation ten cycles into DIV.
        a        = 32'h40C00000;
        b        = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_q", q, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) check("midrst_no_pulse", {31'b0, out_valid}, 32'd0);
        end
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, FULL_LAT, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
